// File: rtl/bus_word_sequencer_pkg.sv
// Shared types and helpers for the bus word sequencer.
// Sizes, state encoding and mask utilities live here.
package word_pkg;

    localparam int BUS_SIZE  = 16;
    localparam int WORD_SIZE = 4;
    localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE;
    localparam int IDX_W     = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

    typedef logic [WORD_NUM-1:0] mask_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Index of the most significant set bit; 0 for an empty mask.
    function automatic logic [IDX_W-1:0] highest_set(input mask_t m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // True when at most one bit of the mask is set.
    function automatic logic onehot_or_zero(input mask_t m);
        return (m & (m - mask_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/bus_word_sequencer_if.sv
// Bus-side and word-side handshake bundle of the sequencer.
// slave is the sequencer view, master the environment view.
interface bus_word_sequencer_if;
    import word_pkg::*;

    logic [BUS_SIZE-1:0]  bus_in;
    logic                 bus_valid;
    logic                 bus_ready;
    logic                 skip_zero;
    logic [WORD_SIZE-1:0] data_out;
    logic                 control_out;
    logic [IDX_W-1:0]     idx_out;
    logic                 last_out;
    logic                 valid_out;
    logic                 out_ready;
    logic                 drop_pulse;

    modport slave (
        input  bus_in, bus_valid, skip_zero, out_ready,
        output bus_ready, data_out, control_out, idx_out,
        output last_out, valid_out, drop_pulse
    );

    modport master (
        output bus_in, bus_valid, skip_zero, out_ready,
        input  bus_ready, data_out, control_out, idx_out,
        input  last_out, valid_out, drop_pulse
    );

endinterface

// File: rtl/bus_word_sequencer_stage.sv
// Per-word stage: forwards the selected word and its
// nonzero control flag.
module word_managing_stage
    import word_pkg::*;
(
    input  logic [WORD_SIZE-1:0] word_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 control_o
);

    assign data_o    = word_i;
    assign control_o = |word_i;

endmodule

// File: rtl/bus_word_sequencer.sv
// Splits accepted bus values into words, MSW first,
// optionally dropping all-zero words.
module bus_word_sequencer
    import word_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    bus_word_sequencer_if.slave bus
);

    state_e              state_q, state_d;
    logic [BUS_SIZE-1:0] buf_q, buf_d;
    mask_t               mask_q, mask_d;
    logic                drop_q, drop_d;

    logic [IDX_W-1:0]     cur;
    logic                 valid;
    logic                 last;
    logic                 ready;
    logic                 accept;
    logic                 beat;
    mask_t                new_mask;
    logic [WORD_SIZE-1:0] sel_word;
    logic [IDX_W-1:0]     idx;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            mask_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            drop_q  <= drop_d;
        end
    end

    // Pending-word mask for an incoming bus value.
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            new_mask[i] = !bus.skip_zero ||
                (bus.bus_in[i*WORD_SIZE +: WORD_SIZE] != '0);
        end
    end

    // Next state: retire the current word, then load on accept.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        mask_d  = mask_q;
        drop_d  = 1'b0;
        if (beat) begin
            mask_d = mask_q & ~(mask_t'(1) << cur);
            if (last) state_d = IDLE;
        end
        if (accept) begin
            buf_d = bus.bus_in;
            if (new_mask != '0) begin
                mask_d  = new_mask;
                state_d = SEND;
            end else begin
                mask_d  = '0;
                state_d = IDLE;
                drop_d  = 1'b1;
            end
        end
    end

    // Outputs: word selection, handshakes, zeroing when idle.
    always_comb begin
        valid    = (state_q == SEND);
        cur      = highest_set(mask_q);
        last     = valid && onehot_or_zero(mask_q);
        beat     = valid && bus.out_ready;
        ready    = !valid || (last && bus.out_ready);
        accept   = bus.bus_valid && ready;
        idx      = valid ? cur : '0;
        sel_word = '0;
        if (valid) begin
            sel_word = buf_q[int'(cur)*WORD_SIZE +: WORD_SIZE];
        end
    end

    word_managing_stage u_stage (
        .word_i    (sel_word),
        .data_o    (bus.data_out),
        .control_o (bus.control_out)
    );

    assign bus.valid_out  = valid;
    assign bus.idx_out    = idx;
    assign bus.last_out   = last;
    assign bus.bus_ready  = ready;
    assign bus.drop_pulse = drop_q;

endmodule
